// File: rtl/score_bcd_converter_pkg.sv
// Shared types and constants for the binary-to-BCD score converter.
package score_bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJUST_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJUST_ADD       = 4'd3;

endpackage

// File: rtl/score_bcd_converter_if.sv
// Request/result bundle between a score source and the BCD converter.
interface score_bcd_converter_if #(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, output binary, input busy, input done, input bcd);
    modport slave  (input start, input binary, output busy, output done, output bcd);
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import score_bcd_converter_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Inputs never exceed 9, so the 4-bit sum cannot overflow.
    assign adjusted = (digit >= BCD_ADJUST_THRESHOLD) ? digit + BCD_ADJUST_ADD : digit;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential shift-and-add-3 converter: one bit per cycle, result latched on completion.
module score_bcd_converter
    import score_bcd_converter_pkg::*;
#(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned DIGITS = 4
) (
    input logic                  clk,
    input logic                  rst,
    score_bcd_converter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CMB_W = BCD_W + WIDTH;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   adj;
    logic [CMB_W-1:0]   shifted;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (acc_q[4*k +: 4]),
            .adjusted (adj[4*k +: 4])
        );
    end

    // The adjusted accumulator's MSB shifts out; it is always zero for valid sizing.
    assign shifted = {adj, sr_q} << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CONVERT;
                    sr_d    = bus.binary;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONVERT: begin
                acc_d = shifted[CMB_W-1:WIDTH];
                sr_d  = shifted[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    bcd_d   = shifted[CMB_W-1:WIDTH];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sr_q    <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.busy = (state_q == CONVERT);
    assign bus.done = (state_q == DONE);
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed and sampled-random checks of score_bcd_converter against a decimal model.
module tb_score_bcd_converter;

    localparam int unsigned WIDTH  = 13;
    localparam int unsigned DIGITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    score_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    score_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int done_count = 0;

    // Model: phase 0 idle, 1..WIDTH converting, WIDTH+1 result presented.
    int                  phase   = 0;
    logic [WIDTH-1:0]    cap     = '0;
    logic [4*DIGITS-1:0] exp_bcd = '0;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned         x;
        r = '0;
        x = v;
        for (int k = 0; k < int'(DIGITS); k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= 0;
            exp_bcd <= '0;
        end else if (phase == 0) begin
            if (bus.start) begin
                phase <= 1;
                cap   <= bus.binary;
            end
        end else if (phase == int'(WIDTH)) begin
            phase   <= phase + 1;
            exp_bcd <= to_bcd(int'(cap));
        end else if (phase == int'(WIDTH) + 1) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        bit bad;
        check("busy", 32'(bus.busy), 32'(phase >= 1 && phase <= int'(WIDTH)));
        check("done", 32'(bus.done), 32'(phase == int'(WIDTH) + 1));
        check("bcd", 32'(bus.bcd), 32'(exp_bcd));
        bad = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bus.bcd[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        check("digit_range", 32'(bad), 32'd0);
        if (bus.done) done_count <= done_count + 1;
    end

    task automatic wait_done(input string name, output int nb);
        bit got;
        got = 1'b0;
        nb  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) nb++;
        end
        check(name, 32'(got), 32'd1);
    endtask

    task automatic run(input logic [WIDTH-1:0] v, output int nb);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.binary = v;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.binary = WIDTH'($urandom);
        wait_done("done_timeout", nb);
        check("result_vs_div10", 32'(bus.bcd), 32'(to_bcd(int'(v))));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int dc;
        int c1;
        int c2;
        bus.start  = 1'b0;
        bus.binary = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_bcd", 32'(bus.bcd), 32'h0);
        rst = 1'b0;

        run(13'd1234, nb);
        check("bcd_1234", 32'(bus.bcd), 32'h1234);
        check("busy_len_1234", 32'(nb), 32'd13);
        run(13'd8191, nb);
        check("bcd_8191", 32'(bus.bcd), 32'h8191);
        check("busy_len_8191", 32'(nb), 32'd13);
        run(13'd0, nb);
        check("bcd_0", 32'(bus.bcd), 32'h0000);
        check("busy_len_0", 32'(nb), 32'd13);

        // Start pulse in the middle of a conversion must be ignored.
        @(posedge clk); #1;
        dc = done_count;
        bus.start  = 1'b1;
        bus.binary = 13'd1234;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.binary = 13'd42;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        wait_done("done_timeout_ignore", nb);
        check("bcd_ignore_42", 32'(bus.bcd), 32'h1234);
        repeat (20) @(negedge clk);
        check("single_done_pulse", 32'(done_count - dc), 32'd1);

        // Reset aborts a conversion in its sixth cycle.
        run(13'd500, nb);
        check("bcd_500", 32'(bus.bcd), 32'h0500);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.binary = 13'd777;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        dc  = done_count;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd", 32'(bus.bcd), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 32'(done_count - dc), 32'd0);
        run(13'd999, nb);
        check("bcd_999", 32'(bus.bcd), 32'h0999);

        // Start held high: back-to-back conversions, binary stepped after the first capture.
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.binary = 13'd9;
        @(posedge clk); #1;
        bus.binary = 13'd10;
        wait_done("done_timeout_b2b1", nb);
        check("bcd_9", 32'(bus.bcd), 32'h0009);
        c1 = cyc;
        wait_done("done_timeout_b2b2", nb);
        check("bcd_10", 32'(bus.bcd), 32'h0010);
        c2 = cyc;
        bus.start = 1'b0;
        check("b2b_period", 32'(c2 - c1), 32'd15);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 1200; i++) begin
            run(WIDTH'($urandom_range(0, 8191)), nb);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
